// File: rtl/isqrt_iter.sv
// isqrt_iter: restoring digit-by-digit integer square root, one root bit per clock.
// Define ISQRT_ROUND_EN for a round-to-nearest (saturating) root; default is floor.
module isqrt_iter #(
  parameter int WIDTH = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   radicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(H + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("isqrt_iter: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state, state_d;
  logic [WIDTH-1:0] x;
  logic [H+1:0]   r;
  logic [H-1:0]   q;
  logic [CW-1:0]  cnt;
  logic [H-1:0]   root_q;
  logic [H:0]     rem_q;

  logic [H+1:0]   r_sh;
  logic [H+2:0]   t;
  logic [H+1:0]   r_nx;
  logic [H-1:0]   q_nx;
  logic [H-1:0]   root_fin;
  logic           last;

  // One restoring step: bring down two radicand bits, trial-subtract 4q+1.
  assign r_sh = {r[H-1:0], x[WIDTH-1 -: 2]};
  assign t    = {1'b0, r_sh} - {1'b0, q, 2'b01};
  assign r_nx = t[H+2] ? r_sh : t[H+1:0];
  assign q_nx = {q[H-2:0], ~t[H+2]};
  assign last = (cnt == CW'(1));

`ifdef ISQRT_ROUND_EN
  logic round_up;
  // Round up when the remainder exceeds the floor root, saturating at all-ones.
  assign round_up = (r_nx > {2'b00, q_nx}) && !(&q_nx);
  assign root_fin = round_up ? q_nx + 1'b1 : q_nx;
`else
  assign root_fin = q_nx;
`endif

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign root      = root_q;
  assign rem       = rem_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state decode: accept, iterate H times, hold result until taken.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, shift/iterate in BUSY, register result on last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      r      <= '0;
      q      <= '0;
      cnt    <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (state == IDLE && in_valid) begin
      x   <= radicand;
      r   <= '0;
      q   <= '0;
      cnt <= CW'(H);
    end else if (state == BUSY) begin
      x   <= {x[WIDTH-3:0], 2'b00};
      r   <= r_nx;
      q   <= q_nx;
      cnt <= cnt - 1'b1;
      if (last) begin
        root_q <= root_fin;
        rem_q  <= r_nx[H:0];
      end
    end
  end

endmodule

// File: doc/isqrt_iter.md
# isqrt_iter

Iterative integer square-root unit: the inverse of the pipelined square/difference-square DSP kernels. It accepts an unsigned radicand over a valid/ready handshake. It produces the floor square root and the remainder, resolving one root bit per clock with a restoring digit-by-digit algorithm. It sits downstream of squarer datapaths, for example to recover magnitudes from `square_out`-style results, and uses fabric logic only, with no DSP block.

## Interface
- `WIDTH`, default 34: radicand width. Must be even and ≥ 4; any other value is an elaboration error.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: radicand offered.
- `in_ready` out 1: unit can accept a radicand.
- `radicand` in WIDTH: unsigned operand. Sampled on an accept.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `root` out WIDTH/2: square root. Floor by default; see Configuration.
- `rem` out WIDTH/2+1: `radicand − floor_root²`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - BUSY: iterating.
  - DONE: `out_valid`=1.
- IDLE → BUSY on `in_valid && in_ready`:
  - latch radicand into shift register `x`;
  - clear partial remainder `r` (WIDTH/2+2 bits) and root `q`;
  - load counter with WIDTH/2.
- Each BUSY cycle:
  - `r' = (r<<2) | x[WIDTH-1:WIDTH-2]`.
  - `t = r' − ((q<<2)|1)`.
  - If t ≥ 0: `r=t`, `q=(q<<1)|1`. Otherwise: `r=r'`, `q=q<<1`.
  - `x <<= 2`; decrement the counter.
- BUSY → DONE on the cycle that performs the last iteration (counter == 1).
- DONE → IDLE on `out_valid && out_ready`.
- `root`/`rem` are registered. They stay stable throughout DONE and hold their last values in IDLE/BUSY.
- `in_ready` is 0 in BUSY and DONE. There is no overlap of operations; `in_valid` is ignored outside IDLE.
- `rem` ≤ 2·root always fits in WIDTH/2+1 bits.
- Reset, asserted at any time including mid-BUSY or in DONE, takes effect immediately:
  - state → IDLE;
  - `in_ready`=1 after deassertion (0 while `rst_n` is low);
  - `out_valid`=0, `root`=0, `rem`=0;
  - internal `x`, `r`, `q`, counter cleared.
  - The operation in flight is discarded; no partial result is ever presented.

## Timing
- Accept at edge 0. Iterations occur at edges 1..WIDTH/2. `out_valid` is high after edge WIDTH/2, i.e. latency is WIDTH/2 cycles (17 at default).
- Result handshake at the first edge with `out_ready` high in DONE. `out_ready` held high gives a minimum initiation interval of WIDTH/2+2 cycles.
- `out_ready` may be high before `out_valid`; only the DONE-state edge counts.
- `out_valid` has no combinational dependence on `out_ready`. `in_ready` is a pure state decode.

## Configuration
- `ISQRT_ROUND_EN` defined:
  - `root` is rounded to nearest: floor_root+1 when `rem` > floor_root, else floor_root.
  - Saturates at 2^(WIDTH/2)−1 when the increment would overflow.
  - The rounding compare/increment is folded into the final BUSY iteration, so latency is unchanged.
  - `rem` still reports the floor remainder.
- Undefined: `root` is the floor square root. No compare/increment logic is synthesised.

## Test plan
- `radicand`=0: `root`=0, `rem`=0, with `out_valid` exactly 17 cycles after the accept.
- `radicand`=1_000_000: `root`=1000, `rem`=0. Next, 99: `root`=9, `rem`=18, or `root`=10 with `ISQRT_ROUND_EN`.
- `radicand`=2^34−1: `root`=131071, `rem`=262142. With `ISQRT_ROUND_EN`, `root` saturates at 131071.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. `out_valid`, `root`, `rem` must stay stable and `in_ready`=0. When `out_ready` rises, return to IDLE on the next edge.
- Back-to-back: `in_valid` and `out_ready` held high with random radicands. Initiation interval must be 19 cycles, and every result must match a floor-sqrt reference model over 10k random values plus all perfect squares k² and k²−1.
- Reset mid-BUSY (cycle 8), `rst_n` low for 1 cycle: outputs are immediately 0 and there is no `out_valid`. A new radicand 144 then yields `root`=12, `rem`=0.
